// File: rtl/inv_pipe.sv
// inv_pipe: elastic STAGES-deep register pipeline carrying WIDTH-bit words
// with a per-word transform applied when the word is accepted.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : producer handshake (in_ready is combinational)
//   in_data, mode, mask : word and its transform select, sampled on accept
//                         mode 0 pass, 1 invert, 2 xor mask, 3 bit-reverse
//   out_valid/out_ready : consumer handshake, out_valid/out_data registered
//   out_data            : transformed word in the last stage
//   count               : words currently held (0..STAGES)

// One pipeline register: loads from its source when told to advance.
//   load         : stage advances this cycle
//   src_v, src_d : upstream valid/data
//   v, d         : held valid/data
module inv_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             src_v,
  input  logic [WIDTH-1:0] src_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= 1'b0;
      d <= '0;
    end else if (load) begin
      v <= src_v;
      // Bubble moving in leaves old data in place; v marks it dead.
      if (src_v) d <= src_d;
    end
  end
endmodule

module inv_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CW     = $clog2(STAGES+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);
  logic [STAGES-1:0]            v;
  logic [STAGES-1:0][WIDTH-1:0] d;
  logic [STAGES-1:0]            adv;
  logic                         acc, xfer;
  logic [WIDTH-1:0]             xd;

  function automatic logic [WIDTH-1:0] xform(input logic [WIDTH-1:0] x,
                                             input logic [1:0]       m,
                                             input logic [WIDTH-1:0] k);
    logic [WIDTH-1:0] r;
    r = x;
    case (m)
      2'd0: r = x;
      2'd1: r = ~x;
      2'd2: r = x ^ k;
      default: for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    endcase
    return r;
  endfunction

  // Advance chain resolved from the output side back to stage 0, so a
  // consumer pop frees the whole column in the same cycle.
  always_comb begin
    logic dr;
    adv = '0;
    dr  = v[STAGES-1] && out_ready;
    for (int s = STAGES-1; s >= 0; s--) begin
      adv[s] = !v[s] || dr;
      dr     = adv[s];
    end
  end

  assign in_ready = adv[0];
  assign acc      = in_valid && in_ready;
  assign xfer     = v[STAGES-1] && out_ready;
  assign xd       = xform(in_data, mode, mask);

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    logic             sv;
    logic [WIDTH-1:0] sd;
    if (s == 0) begin : g_head
      assign sv = acc;
      assign sd = xd;
    end else begin : g_body
      assign sv = v[s-1];
      assign sd = d[s-1];
    end
    inv_pipe_stage #(.WIDTH(WIDTH)) u_stg (
      .clk   (clk),
      .rst   (rst),
      .load  (adv[s]),
      .src_v (sv),
      .src_d (sd),
      .v     (v[s]),
      .d     (d[s])
    );
  end

  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({acc, xfer})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_pipe.sv
module tb_inv_pipe;
  localparam int W = 8;
  localparam int S = 2;
  localparam int CW = $clog2(S+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [1:0]    mode = '0;
  logic [W-1:0]  mask = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;

  inv_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .mask(mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    int           c;
    bit           lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Monitor: every output transfer pops the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_word", {24'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("out_data", {24'd0, out_data}, {24'd0, e.d});
        if (e.lat) chk("latency", cyc - e.c, S);
      end
    end
  end

  // Called at posedge+1: offer a word that must be taken at the next edge.
  task automatic put(input logic [W-1:0] dat, input logic [1:0] md,
                     input logic [W-1:0] mk, input logic [W-1:0] ex, input bit lat);
    exp_t e;
    in_valid = 1'b1; in_data = dat; mode = md; mask = mk;
    @(negedge clk);
    chk("in_ready_accept", {31'd0, in_ready}, 32'd1);
    e.d = ex; e.c = cyc; e.lat = lat;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_done", q.size(), 0);
  endtask

  initial begin
    #12 rst = 1'b0;
    @(posedge clk); #1;
    // reset state
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {24'd0, out_data}, 0);
    chk("rst_count", {30'd0, count}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);

    // streaming, all four modes, one per cycle
    out_ready = 1'b1;
    put(8'hA5, 2'd0, 8'h00, 8'hA5, 1'b1);
    put(8'hA5, 2'd1, 8'h00, 8'h5A, 1'b1);
    put(8'hA5, 2'd2, 8'h0F, 8'hAA, 1'b1);
    put(8'hA5, 2'd3, 8'h00, 8'hA5, 1'b1);
    put(8'h01, 2'd3, 8'h00, 8'h80, 1'b1);
    put(8'h3C, 2'd2, 8'hFF, 8'hC3, 1'b1);
    in_valid = 1'b0;
    drain();

    // backpressure: third word refused while full
    out_ready = 1'b0;
    put(8'h01, 2'd0, 8'h00, 8'h01, 1'b0);
    put(8'h02, 2'd0, 8'h00, 8'h02, 1'b0);
    in_data = 8'h03; mode = 2'd0;
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 0);
    chk("full_count", {30'd0, count}, 2);
    @(posedge clk); #1;
    chk("full_hold_count", {30'd0, count}, 2);
    chk("full_hold_data", {24'd0, out_data}, 8'h01);
    out_ready = 1'b1;
    put(8'h03, 2'd0, 8'h00, 8'h03, 1'b0);
    chk("flow_count", {30'd0, count}, 2);
    in_valid = 1'b0;
    drain();

    // full with simultaneous in/out for 10 cycles
    out_ready = 1'b0;
    put(8'h10, 2'd0, 8'h00, 8'h10, 1'b0);
    put(8'h11, 2'd1, 8'h00, 8'hEE, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      put(8'h20 + 8'(i), 2'd0, 8'h00, 8'h20 + 8'(i), 1'b0);
      chk("simul_count", {30'd0, count}, 2);
    end
    in_valid = 1'b0;
    drain();

    // mode change while stalled leaves stored word alone
    out_ready = 1'b0;
    put(8'hF0, 2'd1, 8'h00, 8'h0F, 1'b0);
    in_valid = 1'b0; mode = 2'd0; mask = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_out_data", {24'd0, out_data}, 8'h0F);
    chk("stall_out_valid", {31'd0, out_valid}, 1);
    drain();

    // reset mid-stream drops everything without a clock edge
    out_ready = 1'b0;
    put(8'h55, 2'd0, 8'h00, 8'h55, 1'b0);
    put(8'h66, 2'd0, 8'h00, 8'h66, 1'b0);
    in_valid = 1'b0;
    chk("pre_rst_count", {30'd0, count}, 2);
    rst = 1'b1;
    q.delete();
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 0);
    chk("async_rst_count", {30'd0, count}, 0);
    chk("async_rst_data", {24'd0, out_data}, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 1);
    out_ready = 1'b1;
    put(8'h3C, 2'd0, 8'h00, 8'h3C, 1'b1);
    in_valid = 1'b0;
    drain();
    chk("end_count", {30'd0, count}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
